// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer for the shared data-memory
// port. Each grant runs one read or write: a registered address phase, a wait of
// MEM_LATENCY cycles for the memory, then a one-cycle acknowledge.
//
// Handshake: a requester raises req[i] (level) with req_we/req_addr/req_wdata and
// holds them until ack[i] pulses. gnt[i] stays high from the grant edge through
// the ack cycle. Address and data are latched at grant, so changes after the grant
// are ignored, and dropping req mid-transaction does not cancel it.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        err,
  output logic [DATA_W-1:0]           rd_data,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  // One bit wider than the address so MEM_DEPTH itself is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]         state;
  logic [2:0]         cnt;
  logic [IDX_W-1:0]   last_grant;
  logic               we_q;
  logic               oor_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic               win_we;
  logic               win_in_range;
  logic [NUM_REQ-1:0] win_onehot;

  // Round-robin pick: first set req bit after last_grant, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_addr     = req_addr[win_idx*ADDR_W +: ADDR_W];
    win_wdata    = req_wdata[win_idx*DATA_W +: DATA_W];
    win_we       = req_we[win_idx];
    win_in_range = ({1'b0, win_addr} < DEPTH_L);
    win_onehot   = NUM_REQ'(1) << win_idx;
  end

  // Transaction sequencer: IDLE -> ACCESS (MEM_LATENCY cycles) -> ACK -> IDLE.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      gnt         <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rd_data     <= '0;
      mem_address <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state       <= S_ACCESS;
            cnt         <= '0;
            gnt         <= win_onehot;
            last_grant  <= win_idx;
            // Out-of-range accesses never reach the memory: address forced to 0.
            mem_address <= win_in_range ? win_addr : '0;
            mem_wdata   <= win_wdata;
            we_q        <= win_we;
            oor_q       <= !win_in_range;
            mem_we      <= win_we && win_in_range;
          end
        end
        S_ACCESS: begin
          cnt    <= cnt + 3'd1;
          // Write strobe lasts only the first ACCESS cycle.
          mem_we <= 1'b0;
          if (cnt == 3'(MEM_LATENCY - 1)) begin
            rd_data <= (we_q || oor_q) ? '0 : mem_rdata;
            ack     <= gnt;
            err     <= oor_q;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          gnt         <= '0;
          ack         <= '0;
          err         <= 1'b0;
          mem_address <= '0;
          mem_we      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a behavioural
// 1024-word memory. Expected ack/err/rd_data triples are queued as requests are
// issued; a monitor pops one entry per ack pulse.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int W       = NUM_REQ + 1 + DATA_W;

  logic                      clock;
  logic                      nreset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         mem_address;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic [1:0]                state_dbg;

  logic [DATA_W-1:0] mem [0:1023];
  logic              pl_en;
  logic [9:0]        pl_addr;
  logic [DATA_W-1:0] pl_data;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  int checks;
  int failures;

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_DEPTH(1024), .MEM_LATENCY(1)
  ) dut (
    .clock(clock), .nreset(nreset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .err(err), .rd_data(rd_data), .mem_address(mem_address), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  assign mem_rdata = mem[mem_address[9:0]];

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_address[9:0]] <= mem_wdata;
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic e, input logic [15:0] d);
    exp_q.push_back({a, e, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] a,
                         input logic [15:0] d);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_addr[i*16 +: 16]   = a;
    req_wdata[i*16 +: 16]  = d;
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clock);
    pl_en   = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (nreset) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      chk("err_without_ack", 32'(err && (ack == '0)), 32'd0);
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_unexpected actual=%b expected=none at %0t", ack, $time);
        end else begin
          exp_e = exp_q.pop_front();
          chk("ack_err_rdata", 32'({ack, err, rd_data}), 32'(exp_e));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [15:0] fair_data [0:3];

  initial begin
    checks = 0;
    failures = 0;
    fair_data[0] = 16'h1111;
    fair_data[1] = 16'h2222;
    fair_data[2] = 16'h3333;
    fair_data[3] = 16'h4444;
    nreset = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    cyc(2);
    preload(10'h148, 16'h00A5);
    preload(10'h010, 16'h1111);
    preload(10'h020, 16'h2222);
    preload(10'h030, 16'h3333);
    preload(10'h040, 16'h4444);

    // Reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(state_dbg), 0);
    nreset = 1'b1;
    cyc(1);

    // Single read by requester 1
    set_req(1, 1'b0, 16'h0148, 16'h0000);
    push_exp(4'b0010, 1'b0, 16'h00A5);
    cyc(1);
    chk("rd_gnt", 32'(gnt), 32'b0010);
    chk("rd_mem_address", 32'(mem_address), 32'h148);
    chk("rd_busy", 32'(busy), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    drop(1);
    cyc(1);
    chk("rd_busy_ack", 32'(busy), 1);
    cyc(1);
    chk("rd_busy_done", 32'(busy), 0);
    chk("rd_gnt_done", 32'(gnt), 0);
    chk("rd_addr_done", 32'(mem_address), 0);
    chk("rd_data_hold", 32'(rd_data), 32'h00A5);

    // Write by requester 2, then read back by requester 0
    set_req(2, 1'b1, 16'h01C8, 16'h1234);
    push_exp(4'b0100, 1'b0, 16'h0000);
    cyc(1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_address", 32'(mem_address), 32'h1C8);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_gnt", 32'(gnt), 32'b0100);
    drop(2);
    cyc(1);
    chk("wr_mem_we_ack", 32'(mem_we), 0);
    cyc(1);
    set_req(0, 1'b0, 16'h01C8, 16'h0000);
    push_exp(4'b0001, 1'b0, 16'h1234);
    cyc(1);
    drop(0);
    cyc(2);

    // Out-of-range read (first address past the end)
    set_req(0, 1'b0, 16'h0400, 16'h0000);
    push_exp(4'b0001, 1'b1, 16'h0000);
    cyc(1);
    chk("oor_gnt", 32'(gnt), 32'b0001);
    chk("oor_mem_address", 32'(mem_address), 0);
    chk("oor_mem_we", 32'(mem_we), 0);
    drop(0);
    cyc(1);
    chk("oor_mem_we_ack", 32'(mem_we), 0);
    chk("oor_mem_address_ack", 32'(mem_address), 0);
    cyc(1);

    // Out-of-range write must never strobe the memory
    set_req(3, 1'b1, 16'hFFFF, 16'h5555);
    push_exp(4'b1000, 1'b1, 16'h0000);
    cyc(1);
    chk("oorw_mem_we", 32'(mem_we), 0);
    chk("oorw_mem_address", 32'(mem_address), 0);
    drop(3);
    cyc(2);

    // Last valid address: write then read back
    set_req(1, 1'b1, 16'h03FF, 16'h0F0F);
    push_exp(4'b0010, 1'b0, 16'h0000);
    cyc(1);
    chk("top_mem_we", 32'(mem_we), 1);
    chk("top_mem_address", 32'(mem_address), 32'h3FF);
    drop(1);
    cyc(2);
    set_req(2, 1'b0, 16'h03FF, 16'h0000);
    push_exp(4'b0100, 1'b0, 16'h0F0F);
    cyc(1);
    drop(2);
    cyc(2);

    // Fairness after reset: all four held -> 0,1,2,3,0,1
    nreset = 1'b0;
    cyc(1);
    chk("fair_rst_busy", 32'(busy), 0);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'((i + 1) * 16), 16'h0000);
    for (int k = 0; k < 6; k++) push_exp(4'(1 << (k % 4)), 1'b0, fair_data[k % 4]);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("fair_gnt", 32'(gnt), 32'(1 << (k % 4)));
      cyc(2);
    end
    for (int i = 0; i < 4; i++) drop(i);
    cyc(3);
    chk("fair_drained", 32'(exp_q.size()), 0);

    // Reset during ACCESS: immediate abort, priority back to requester 0
    set_req(2, 1'b1, 16'h0050, 16'hBEEF);
    cyc(1);
    chk("abort_pre_mem_we", 32'(mem_we), 1);
    #2 nreset = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_mem_address", 32'(mem_address), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(ack), 0);
    drop(2);
    set_req(3, 1'b0, 16'h0040, 16'h0000);
    set_req(0, 1'b0, 16'h0010, 16'h0000);
    cyc(2);
    push_exp(4'b0001, 1'b0, 16'h1111);
    push_exp(4'b1000, 1'b0, 16'h4444);
    nreset = 1'b1;
    cyc(1);
    chk("abort_first_gnt", 32'(gnt), 32'b0001);
    cyc(2);
    drop(0);
    cyc(1);
    chk("abort_second_gnt", 32'(gnt), 32'b1000);
    drop(3);
    cyc(2);

    // Withdrawn request: ack still pulses, then the other pending requester
    set_req(1, 1'b0, 16'h0148, 16'h0000);
    set_req(2, 1'b0, 16'h0020, 16'h0000);
    push_exp(4'b0010, 1'b0, 16'h00A5);
    push_exp(4'b0100, 1'b0, 16'h2222);
    cyc(1);
    chk("wd_gnt", 32'(gnt), 32'b0010);
    drop(1);
    cyc(3);
    chk("wd_next_gnt", 32'(gnt), 32'b0100);
    drop(2);
    cyc(3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
